// File: rtl/vp_kbd_pkg.sv
// Shared types, ASCII constants and scancode translation for the Videopac key event path.
package vp_kbd_pkg;

    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } kbd_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_GAP
    } tx_state_t;

    localparam int JOY_KEYS = 10;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_YES   = 8'h11;
    localparam logic [7:0] ASCII_NO    = 8'h12;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;

    // Scan code set 2 make codes; anything not listed translates to NUL and is dropped.
    function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h45: a = "0";
            8'h16: a = "1";
            8'h1E: a = "2";
            8'h26: a = "3";
            8'h25: a = "4";
            8'h2E: a = "5";
            8'h36: a = "6";
            8'h3D: a = "7";
            8'h3E: a = "8";
            8'h46: a = "9";
            8'h1C: a = "a";
            8'h32: a = "b";
            8'h21: a = "c";
            8'h23: a = "d";
            8'h24: a = "e";
            8'h2B: a = "f";
            8'h34: a = "g";
            8'h33: a = "h";
            8'h43: a = "i";
            8'h3B: a = "j";
            8'h42: a = "k";
            8'h4B: a = "l";
            8'h3A: a = "m";
            8'h31: a = "n";
            8'h44: a = "o";
            8'h4D: a = "p";
            8'h15: a = "q";
            8'h2D: a = "r";
            8'h1B: a = "s";
            8'h2C: a = "t";
            8'h3C: a = "u";
            8'h2A: a = "v";
            8'h1D: a = "w";
            8'h22: a = "x";
            8'h35: a = "y";
            8'h1A: a = "z";
            8'h29: a = ASCII_SPACE;
            8'h79: a = "+";
            8'h4E: a = "-";
            8'h7C: a = "*";
            8'h4A: a = "/";
            8'h55: a = "=";
            8'h1F: a = ASCII_YES;
            8'h27: a = ASCII_NO;
            8'h5A: a = ASCII_LF;
            8'h66: a = ASCII_BS;
            default: a = ASCII_NUL;
        endcase
        return a;
    endfunction

    // Keypad bits 0..8 are digits '1'..'9', bit 9 is '0'.
    function automatic logic [7:0] numpad_ascii(input logic [3:0] idx);
        return (idx == 4'd9) ? ASCII_ZERO : (ASCII_ONE + {4'd0, idx});
    endfunction

endpackage

// File: rtl/vp_evt_fifo.sv
// Small circular FIFO of key events with show-ahead head output.
module vp_evt_fifo
    import vp_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  kbd_evt_t               push_data,
    input  logic                   pop,
    output kbd_evt_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    kbd_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: flushing the pointers makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vp_key_event_tx.sv
// Turns PS/2 toggle events and keypad button edges into queued ASCII press/release
// events, presented one at a time over the ready/read handshake used by vp_keymap.
module vp_key_event_tx
    import vp_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic [10:0] ps2_key_i,
    input  logic [9:0]  joy_numpad_i,
    input  logic        rx_read_i,
    output logic        rx_data_ready_o,
    output logic [7:0]  rx_ascii_o,
    output logic        rx_released_o,
    output logic        overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t              state;
    logic                   primed;
    logic                   old_toggle;
    logic [JOY_KEYS-1:0]    old_joy;
    logic [JOY_KEYS-1:0]    pend_press;
    logic [JOY_KEYS-1:0]    pend_rel;
    logic [JOY_KEYS-1:0]    eff_press;
    logic [JOY_KEYS-1:0]    eff_rel;
    logic [JOY_KEYS-1:0]    press_clr;
    logic [JOY_KEYS-1:0]    rel_clr;
    logic [7:0]             ps2_ascii;
    logic                   ps2_valid;
    logic                   ps2_push;
    logic                   joy_push;
    kbd_evt_t               joy_evt;
    kbd_evt_t               push_data;
    kbd_evt_t               fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   ext_unused;

    assign ext_unused = ps2_key_i[8];

    // Until the first post-reset clock has captured the inputs, no edge is trusted.
    assign ps2_ascii = ps2_to_ascii(ps2_key_i[7:0]);
    assign ps2_valid = primed && (ps2_key_i[10] != old_toggle) && (ps2_ascii != ASCII_NUL);
    assign ps2_push  = ps2_valid && !fifo_full;
    assign eff_press = pend_press | (primed ? (joy_numpad_i & ~old_joy) : '0);
    assign eff_rel   = pend_rel   | (primed ? (~joy_numpad_i & old_joy) : '0);

    // Keypad arbiter: lowest pending key wins, press before release of the same key.
    always_comb begin
        joy_push  = 1'b0;
        joy_evt   = '0;
        press_clr = '0;
        rel_clr   = '0;
        if (!ps2_push && (fifo_count != CW'(DEPTH))) begin
            for (int i = 0; i < JOY_KEYS; i++) begin
                if (!joy_push && (eff_press[i] || eff_rel[i])) begin
                    joy_push      = 1'b1;
                    joy_evt.ascii = numpad_ascii(4'(i));
                    if (eff_press[i]) begin
                        joy_evt.released = 1'b0;
                        press_clr[i]     = 1'b1;
                    end else begin
                        joy_evt.released = 1'b1;
                        rel_clr[i]       = 1'b1;
                    end
                end
            end
        end
    end

    assign fifo_push = ps2_push || joy_push;
    assign push_data = ps2_push ? kbd_evt_t'{released: ~ps2_key_i[9], ascii: ps2_ascii} : joy_evt;
    assign fifo_pop  = (state == ST_PRESENT) && rx_read_i;

    vp_evt_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (res_n_i),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            primed     <= 1'b0;
            old_toggle <= 1'b0;
            old_joy    <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
            overflow_o <= 1'b0;
        end else begin
            primed     <= 1'b1;
            old_toggle <= ps2_key_i[10];
            old_joy    <= joy_numpad_i;
            pend_press <= eff_press & ~press_clr;
            pend_rel   <= eff_rel & ~rel_clr;
            if (ps2_valid && fifo_full) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // GAP forces ready low for one cycle after every read so the receiver sees a clean edge.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state           <= ST_IDLE;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= 8'h00;
            rx_released_o   <= 1'b0;
        end else begin
            case (state)
                ST_PRESENT: begin
                    if (rx_read_i) begin
                        state           <= ST_GAP;
                        rx_data_ready_o <= 1'b0;
                    end
                end
                default: begin
                    if (!fifo_empty) begin
                        state           <= ST_PRESENT;
                        rx_data_ready_o <= 1'b1;
                        rx_ascii_o      <= fifo_head.ascii;
                        rx_released_o   <= fifo_head.released;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
